// File: rtl/combo_seq_pkg.sv
// Shared types and constants for the combo vector sweep engine.
// Holds the FSM state encoding and the golden Y rule of the combo gate.
package combo_seq_pkg;

   localparam int VEC_W   = 4;
   localparam int NUM_VEC = 16;
   localparam int HIT_W   = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Y = ~A & B & C & ~D, with vec = {A,B,C,D}
   function automatic logic combo_expected(input logic [VEC_W-1:0] vec);
      return ~vec[3] & vec[2] & vec[1] & ~vec[0];
   endfunction

endpackage

// File: rtl/combo_dwell_timer.sv
// Dwell counter: counts while en, wraps at DWELL_CYCLES-1 and pulses tc there.
// Latency: tc is combinational from the count; no backpressure, clr wins over en.
module combo_dwell_timer #(
   parameter int DWELL_CYCLES = 100,
   parameter int CNT_W        = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   assign tc = en & (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/combo_vector_seq.sv
// Sweeps {a,b,c,d} through 16 vectors, DWELL_CYCLES each, sampling y_in at dwell end.
// No backpressure; optional checker enabled by macro COMBO_SEQ_CHECK_EN.
module combo_vector_seq
   import combo_seq_pkg::*;
#(
   parameter int DWELL_CYCLES = 100,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             a,
   output logic             b,
   output logic             c,
   output logic             d,
   input  logic             y_in,
   output logic             busy,
   output logic             done,
   output logic [VEC_W-1:0] vec_idx,
   output logic [HIT_W-1:0] hit_count,
   output logic             first_hit_valid,
   output logic [VEC_W-1:0] first_hit_idx,
   output logic [HIT_W-1:0] mismatch_count
);

   state_t state;
   logic   run;
   logic   tc;
   logic   sweep_go;
   logic   sample;

   assign run      = (state == RUN);
   assign sweep_go = start & ~abort & ~run;
   assign sample   = run & tc & ~abort;

   assign {a, b, c, d} = vec_idx;

   combo_dwell_timer #(
      .DWELL_CYCLES(DWELL_CYCLES),
      .CNT_W       (CNT_W)
   ) u_timer (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (abort | ~run),
      .en   (run),
      .tc   (tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         vec_idx         <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         hit_count       <= '0;
         first_hit_valid <= 1'b0;
         first_hit_idx   <= '0;
      end else if (abort) begin
         // results deliberately left untouched so software can read a partial sweep
         state   <= IDLE;
         vec_idx <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (sweep_go) begin
                  state           <= RUN;
                  vec_idx         <= '0;
                  busy            <= 1'b1;
                  done            <= 1'b0;
                  hit_count       <= '0;
                  first_hit_valid <= 1'b0;
                  first_hit_idx   <= '0;
               end
            end
            RUN: begin
               if (sample) begin
                  hit_count <= hit_count + HIT_W'(y_in);
                  if (y_in && !first_hit_valid) begin
                     first_hit_valid <= 1'b1;
                     first_hit_idx   <= vec_idx;
                  end
                  if (vec_idx == VEC_W'(NUM_VEC - 1)) begin
                     state   <= DONE;
                     vec_idx <= '0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     vec_idx <= vec_idx + 1'b1;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               vec_idx <= '0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

`ifdef COMBO_SEQ_CHECK_EN
   logic [HIT_W-1:0] mis_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mis_q <= '0;
      end else if (sweep_go) begin
         mis_q <= '0;
      end else if (sample && (y_in != combo_expected(vec_idx)) && (mis_q != '1)) begin
         mis_q <= mis_q + 1'b1;
      end
   end

   assign mismatch_count = mis_q;
`else
   assign mismatch_count = '0;
`endif

endmodule
